// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
//
// Registered immediate-generation stage sitting between instruction fetch and
// the operand/ALU stage of the 16-bit accumulator processor. One instruction
// word is accepted per valid/ready handshake. The immediate field chosen by
// imm_sel is sign- or zero-extended to 16 bits. A prefix word (opcode
// PFX_OPCODE in instr[15:12]) supplies the upper 12 bits of a full 16-bit
// immediate for the next non-prefix word. Results leave through a one-entry
// valid/ready output register.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous active-high reset
//   flush        in   1   synchronous flush: drops held prefix, output entry
//                         and the input word presented in the same cycle
//   in_valid     in   1   instr_in / imm_sel valid
//   in_ready     out  1   stage can accept this cycle (!out_valid || out_ready)
//   instr_in     in  16   instruction word
//   imm_sel      in   2   0: instr[0] x16, 1: instr[3:0] sext,
//                         2: instr[7:0] sext, 3: instr[7:0] zext
//   out_valid    out  1   output entry holds a result
//   out_ready    in   1   downstream consumes this cycle
//   out_imm      out 16   extended immediate
//   out_instr    out 16   instruction word the immediate belongs to
//   out_prefixed out  1   out_imm was built from a prefix
//   pfx_overrun  out  1   one-cycle pulse: a prefix replaced an unused prefix
// -----------------------------------------------------------------------------
module imm_extend_stage #(
    parameter logic [3:0] PFX_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr_in,
    input  logic [1:0]  imm_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [15:0] out_instr,
    output logic        out_prefixed,
    output logic        pfx_overrun
);

    // Prefix tracking states
    localparam logic [0:0] ST_NOPFX   = 1'b0;
    localparam logic [0:0] ST_HAVEPFX = 1'b1;

    // Extension format encodings
    localparam logic [1:0] SEL_BIT0   = 2'd0;
    localparam logic [1:0] SEL_NIB_S  = 2'd1;
    localparam logic [1:0] SEL_BYTE_S = 2'd2;
    localparam logic [1:0] SEL_BYTE_Z = 2'd3;

    // Pure bit-replication extension of the selected immediate field.
    function automatic logic [15:0] extend_imm(input logic [15:0] instr,
                                               input logic [1:0]  sel);
        logic [15:0] res;
        case (sel)
            SEL_BIT0:   res = {16{instr[0]}};
            SEL_NIB_S:  res = {{12{instr[3]}}, instr[3:0]};
            SEL_BYTE_S: res = {{8{instr[7]}}, instr[7:0]};
            SEL_BYTE_Z: res = {8'h00, instr[7:0]};
            default:    res = 16'h0000;
        endcase
        return res;
    endfunction

    // State and output registers
    logic [0:0]  state_r;
    logic [11:0] pfx_r;
    logic        out_valid_r;
    logic [15:0] out_imm_r;
    logic [15:0] out_instr_r;
    logic        out_prefixed_r;
    logic        pfx_overrun_r;

    // Next-state values
    logic [0:0]  state_nxt_s;
    logic [11:0] pfx_nxt_s;
    logic        out_valid_nxt_s;
    logic [15:0] out_imm_nxt_s;
    logic [15:0] out_instr_nxt_s;
    logic        out_prefixed_nxt_s;
    logic        pfx_overrun_nxt_s;

    // Handshake qualifiers
    logic        in_ready_s;
    logic        accept_s;
    logic        consume_s;
    logic        is_pfx_s;

    // Ready only looks at the output register and downstream ready, so no
    // combinational path exists from instr_in to any output.
    assign in_ready_s = !out_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready_s;
    assign consume_s  = out_valid_r && out_ready;
    assign is_pfx_s   = (instr_in[15:12] == PFX_OPCODE);

    // Next-state computation for prefix tracking and the output entry
    always_comb begin
        state_nxt_s        = state_r;
        pfx_nxt_s          = pfx_r;
        out_imm_nxt_s      = out_imm_r;
        out_instr_nxt_s    = out_instr_r;
        out_prefixed_nxt_s = out_prefixed_r;
        pfx_overrun_nxt_s  = 1'b0;

        // A consumed entry empties unless a new result replaces it below.
        if (consume_s) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end

        if (accept_s) begin
            if (is_pfx_s) begin
                // Prefix words only load the payload; they produce no entry.
                pfx_nxt_s         = instr_in[11:0];
                state_nxt_s       = ST_HAVEPFX;
                pfx_overrun_nxt_s = (state_r == ST_HAVEPFX);
            end else begin
                out_instr_nxt_s = instr_in;
                out_valid_nxt_s = 1'b1;
                state_nxt_s     = ST_NOPFX;
                case (state_r)
                    ST_HAVEPFX: begin
                        // Prefixed form ignores imm_sel entirely.
                        out_imm_nxt_s      = {pfx_r, instr_in[3:0]};
                        out_prefixed_nxt_s = 1'b1;
                    end
                    ST_NOPFX: begin
                        out_imm_nxt_s      = extend_imm(instr_in, imm_sel);
                        out_prefixed_nxt_s = 1'b0;
                    end
                    default: begin
                        out_imm_nxt_s      = extend_imm(instr_in, imm_sel);
                        out_prefixed_nxt_s = 1'b0;
                    end
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Register update with reset > flush > normal priority
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_NOPFX;
            pfx_r          <= 12'h000;
            out_valid_r    <= 1'b0;
            out_imm_r      <= 16'h0000;
            out_instr_r    <= 16'h0000;
            out_prefixed_r <= 1'b0;
            pfx_overrun_r  <= 1'b0;
        end else if (flush) begin
            // The word presented during flush is dropped; data fields hold.
            state_r        <= ST_NOPFX;
            out_valid_r    <= 1'b0;
            pfx_overrun_r  <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            pfx_r          <= pfx_nxt_s;
            out_valid_r    <= out_valid_nxt_s;
            out_imm_r      <= out_imm_nxt_s;
            out_instr_r    <= out_instr_nxt_s;
            out_prefixed_r <= out_prefixed_nxt_s;
            pfx_overrun_r  <= pfx_overrun_nxt_s;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_imm      = out_imm_r;
    assign out_instr    = out_instr_r;
    assign out_prefixed = out_prefixed_r;
    assign pfx_overrun  = pfx_overrun_r;

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Registered immediate-generation stage between instruction fetch and the operand/ALU stage of the 16-bit multi-register accumulator processor. Accepts one 16-bit instruction word per handshake and extracts the immediate field selected by the decoder. The field is sign- or zero-extended to 16 bits, including the 1-bit flag extension used by conditional instructions. A two-word prefix mechanism builds full 16-bit immediates. Results are presented through a one-entry valid/ready output register.

## Interface
- PFX_OPCODE, 4'hF: opcode in instr[15:12] that marks a prefix word.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; one clock, sampled on the rising clk edge.
- flush  in  1  synchronous pipeline flush. Discards the held prefix and the output entry.
- in_valid  in  1  instr_in/imm_sel are valid.
- in_ready  out  1  stage can accept this cycle.
- instr_in  in  16  instruction word.
- imm_sel  in  2  extension format:
  - 0: instr[0] replicated ×16
  - 1: instr[3:0] sign-extended
  - 2: instr[7:0] sign-extended
  - 3: instr[7:0] zero-extended
- out_valid  out  1  output entry holds a result.
- out_ready  in  1  downstream consumes this cycle.
- out_imm  out  16  extended immediate.
- out_instr  out  16  instruction word the immediate belongs to.
- out_prefixed  out  1  out_imm was built from a prefix.
- pfx_overrun  out  1  one-cycle pulse: a prefix replaced an unconsumed prefix.

## Operation
- State machine: NOPFX, HAVEPFX. A 12-bit pfx_reg holds the prefix payload.
- Accept condition is in_valid && in_ready, where in_ready = !out_valid || out_ready. The stage is combinational-ready and holds no skid entry.
- Accepted word with instr[15:12] == PFX_OPCODE:
  - pfx_reg <= instr[11:0]; state goes to HAVEPFX.
  - No output entry is produced. out_valid clears if the current entry is consumed this cycle.
  - If already in HAVEPFX, the new payload overwrites the old one and pfx_overrun pulses high for 1 cycle.
- Accepted non-prefix word in NOPFX:
  - out_imm <= extension per imm_sel.
  - out_instr <= instr_in; out_prefixed <= 0; out_valid <= 1.
- Accepted non-prefix word in HAVEPFX:
  - out_imm <= {pfx_reg, instr_in[3:0]}; imm_sel is ignored.
  - out_prefixed <= 1; out_instr <= instr_in; out_valid <= 1.
  - State returns to NOPFX.
- Output handshake:
  - out_valid && out_ready with no new accept: out_valid <= 0.
  - Consume and accept in the same cycle: the entry is replaced and out_valid stays 1.
  - While out_valid && !out_ready: out_imm, out_instr and out_prefixed hold stable.
- flush: state <= NOPFX, out_valid <= 0, pfx_overrun <= 0. The input word in the flush cycle is dropped even if in_valid=1.
- Priority is reset > flush > normal operation.
- Reset values:
  - out_valid 0, out_imm 16'h0000, out_instr 16'h0000.
  - out_prefixed 0, pfx_overrun 0.
  - State NOPFX, pfx_reg 12'h000.
  - in_ready reads 1 in the cycle after reset deasserts.
- Extension arithmetic is pure bit replication; no saturation, no wrap.
  - Format 1: 4'h8 -> 16'hFFF8.
  - Format 2: 8'h80 -> 16'hFF80.
  - Format 3: 8'h80 -> 16'h0080.

## Timing
- Latency: 1 clk from accept edge to out_valid/out_imm updated.
- Throughput: 1 non-prefix word per cycle with out_ready held high.
- A prefix pair costs 2 accepts for 1 output.
- No combinational path from instr_in to any output. in_ready depends combinationally only on out_valid and out_ready.
- pfx_overrun is registered and high for exactly the cycle after the overwriting accept.
- Reset or flush asserted mid-prefix (HAVEPFX): the next non-prefix word is extended normally, with out_prefixed=0.
- Reset asserted while out_valid && !out_ready: the entry is lost and out_valid=0 on the next edge.

## Test plan
- Reset check: assert reset 2 cycles with in_valid=1 -> out_valid=0, out_imm=16'h0000, out_prefixed=0, in_ready=1 after release.
- Formats:
  - instr 16'h1231 sel 0 -> 16'hFFFF.
  - 16'h1230 sel 0 -> 16'h0000.
  - 16'h20F8 sel 1 -> 16'hFFF8.
  - 16'h3080 sel 2 -> 16'hFF80.
  - 16'h3080 sel 3 -> 16'h0080.
  - Each appears exactly 1 cycle after accept.
- Prefix: F123 then 0x4005 -> one output, out_imm=16'h1235, out_prefixed=1, out_instr=16'h4005. No output follows the F123 accept.
- Overrun: F111, F222, 0x5003 -> pfx_overrun pulses once after F222 accept, out_imm=16'h2223.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, out_imm held; release -> back-to-back outputs, no word lost or duplicated.
- Flush in HAVEPFX: F7AB, flush, then 16'h20F8 sel 1 -> out_imm=16'hFFF8, out_prefixed=0.
